// File: rtl/mvau_pkg.sv
// Shared sizing helpers for the matrix-vector unit PE datapath.
// Widths of popcount results and fold accumulators.
package mvau_pkg;

    function automatic int popcnt_w(input int simd);
        return $clog2(simd + 1);
    endfunction

    // Smallest accumulator that holds SIMD*SF, plus a sign bit when bipolar.
    function automatic int acc_w(input int simd, input int sf, input int bip);
        return $clog2(simd * sf + 1) + bip;
    endfunction

endpackage

// File: rtl/mvu_popcount.sv
// Combinational popcount of one SIMD-wide beat of XNOR products.
// Pure function of vec; the caller registers the result.
module mvu_popcount
    import mvau_pkg::*;
#(
    parameter int SIMD = 4
) (
    input  logic [SIMD-1:0]             vec,
    output logic [popcnt_w(SIMD)-1:0]   cnt
);

    localparam int PW = popcnt_w(SIMD);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < SIMD; i++) begin
            cnt = cnt + PW'(vec[i]);
        end
    end

endmodule

// File: rtl/mvu_pe_popcount_acc.sv
// Binary PE tail: popcount each beat, accumulate over SF beats,
// emit one unipolar or bipolar dot product per fold.
module mvu_pe_popcount_acc
    import mvau_pkg::*;
#(
    parameter int SIMD    = 4,
    parameter int SF      = 8,
    parameter int TDstI   = 16,
    parameter int BIPOLAR = 0
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic [SIMD-1:0]  in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [TDstI-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PW = popcnt_w(SIMD);
    localparam int CW = (SF > 1) ? $clog2(SF) : 1;

    if (SF < 1 || TDstI < acc_w(SIMD, SF, BIPOLAR)) begin : g_bad_cfg
        $error("mvu_pe_popcount_acc: SF must be >= 1 and TDstI wide enough");
    end

    logic [PW-1:0]    pc;
    logic [PW-1:0]    s1_pc;
    logic             s1_v;
    logic             s1_first;
    logic             s1_last;
    logic [CW-1:0]    cnt;
    logic [TDstI-1:0] acc;
    logic [TDstI-1:0] acc_n;
    logic [TDstI-1:0] res;
    logic             adv;
    logic             is_last;

    mvu_popcount #(.SIMD(SIMD)) u_pc (
        .vec (in_vec),
        .cnt (pc)
    );

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign is_last  = (cnt == CW'(SF - 1));

    always_comb begin
        acc_n = s1_first ? TDstI'(s1_pc) : acc + TDstI'(s1_pc);
        res   = acc_n;
        if (BIPOLAR != 0) begin
            res = (acc_n << 1) - TDstI'(SIMD * SF);
        end
    end

    // Whole pipeline stalls together so nothing is dropped under backpressure.
    always_ff @(posedge aclk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_pc     <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_pc    <= pc;
                s1_first <= (cnt == '0);
                s1_last  <= is_last;
                cnt      <= is_last ? '0 : cnt + 1'b1;
            end
            if (s1_v) begin
                acc <= acc_n;
            end
            if (s1_v && s1_last) begin
                out_data  <= res;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
